// File: rtl/fp16_mul_host_driver.sv
// Host-side initiator for the byte-serial FP16 log-multiplier tile.
// Serialises operand pairs onto the tile pins and collects the 16-bit product.
module fp16_mul_host_driver #(
    parameter logic [7:0] START_BYTE  = 8'h01,
    parameter int         PROC_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        busy,
    output logic [7:0]  dut_ui,
    output logic [7:0]  dut_uio,
    input  logic [7:0]  dut_uo
);

    localparam int FLUSH_LEN = PROC_CYCLES + 5;
    localparam int CW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [3:0] {
        S_FLUSH,
        S_IDLE,
        S_START,
        S_LO,
        S_HI,
        S_WAIT,
        S_CAP_LO,
        S_CAP_HI,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   a_q;
    logic [15:0]   b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FLUSH;
            cnt        <= CW'(FLUSH_LEN - 1);
            a_q        <= '0;
            b_q        <= '0;
            dut_ui     <= '0;
            dut_uio    <= '0;
            out_result <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
        end else begin
            // Buses idle at zero unless a byte slot drives them below
            dut_ui  <= '0;
            dut_uio <= '0;
            unique case (state)
                S_FLUSH: begin
                    if (cnt == '0) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        dut_ui   <= START_BYTE;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    dut_ui  <= a_q[7:0];
                    dut_uio <= b_q[7:0];
                    state   <= S_LO;
                end
                S_LO: begin
                    dut_ui  <= a_q[15:8];
                    dut_uio <= b_q[15:8];
                    state   <= S_HI;
                end
                S_HI: begin
                    cnt   <= CW'(PROC_CYCLES);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_CAP_LO;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_CAP_LO: begin
                    out_result[7:0] <= dut_uo;
                    state           <= S_CAP_HI;
                end
                S_CAP_HI: begin
                    out_result[15:8] <= dut_uo;
                    out_valid        <= 1'b1;
                    busy             <= 1'b0;
                    state            <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_FLUSH;
                    cnt   <= CW'(FLUSH_LEN - 1);
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_mul_host_driver.sv
// Bench for fp16_mul_host_driver: tile peer model, cycle model and directed vectors.
module tb_fp16_mul_host_driver;

    localparam int P = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] out_result;
    logic [7:0]  dut_ui;
    logic [7:0]  dut_uio;
    logic [7:0]  dut_uo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp16_mul_host_driver #(.START_BYTE(8'h01), .PROC_CYCLES(P)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .busy(busy),
        .dut_ui(dut_ui),
        .dut_uio(dut_uio),
        .dut_uo(dut_uo)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Product table of the tile; unknown pairs get a simple byte mix
    function automatic logic [15:0] tile_fn(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00 && b == 16'h3C00) return 16'h3C00;
        if (a == 16'h4000 && b == 16'h4200) return 16'h46A3;
        if (a == 16'h1234 && b == 16'hABCD) return 16'hC35A;
        return a ^ {b[7:0], b[15:8]};
    endfunction

    // Tile peer: start byte, two operand bytes, then result at k=P+4 / P+5
    int          t_state = 0;
    int          t_cnt = 0;
    logic [15:0] t_a = '0;
    logic [15:0] t_b = '0;
    logic [15:0] t_r;
    logic [7:0]  garbage = 8'hE7;

    always @(posedge clk) begin
        garbage <= 8'($urandom);
        case (t_state)
            0: if (dut_ui != 8'h00) t_state <= 1;
            1: begin
                t_a[7:0] <= dut_ui;
                t_b[7:0] <= dut_uio;
                t_state  <= 2;
            end
            2: begin
                t_a[15:8] <= dut_ui;
                t_b[15:8] <= dut_uio;
                t_cnt     <= 0;
                t_state   <= 3;
            end
            default: begin
                if (t_cnt == P + 2) t_state <= 0;
                t_cnt <= t_cnt + 1;
            end
        endcase
    end

    assign t_r    = tile_fn(t_a, t_b);
    assign dut_uo = (t_state == 3 && t_cnt == P + 1) ? t_r[7:0] :
                    (t_state == 3 && t_cnt == P + 2) ? t_r[15:8] : garbage;

    // Cycle model: m_k is cycles since the accept edge, -1 when none in flight
    int          m_flush = 0;
    int          m_k = -1;
    bit          m_valid = 1'b0;
    bit          m_ok = 1'b0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic [15:0] m_res = '0;

    always @(posedge clk) begin
        logic [15:0] r;
        r = tile_fn(m_a, m_b);
        if (rst) begin
            m_flush = P + 5;
            m_k     = -1;
            m_valid = 1'b0;
            m_res   = '0;
            m_ok    = 1'b1;
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_k < 0) begin
            if (in_valid) begin
                m_k = 0;
                m_a = in_a;
                m_b = in_b;
            end
        end else if (m_k == P + 5) begin
            m_res[15:8] = r[15:8];
            m_valid     = 1'b1;
            m_k         = -1;
        end else begin
            if (m_k == P + 4) m_res[7:0] = r[7:0];
            m_k++;
        end
    end

    always @(negedge clk) begin
        logic [7:0] eu;
        logic [7:0] ev;
        if (m_ok) begin
            eu = 8'h00;
            ev = 8'h00;
            if (m_k == 0) begin
                eu = 8'h01;
            end else if (m_k == 1) begin
                eu = m_a[7:0];
                ev = m_b[7:0];
            end else if (m_k == 2) begin
                eu = m_a[15:8];
                ev = m_b[15:8];
            end
            chk("dut_ui", 16'(dut_ui), 16'(eu));
            chk("dut_uio", 16'(dut_uio), 16'(ev));
            chk("in_ready", 16'(in_ready), 16'(m_flush == 0 && m_k < 0 && !m_valid));
            chk("busy", 16'(busy), 16'(m_flush > 0 || m_k >= 0));
            chk("out_valid", 16'(out_valid), 16'(m_valid));
            chk("out_result", out_result, m_res);
        end
    end

    logic [7:0] ui_log [0:63];
    logic [7:0] uio_log[0:63];

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("in_ready_wait", 16'(in_ready), 16'd1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            ui_log[n]  = dut_ui;
            uio_log[n] = dut_uio;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic rdy, output int lat);
        wait_ready();
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic count_flush(output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (!in_ready && n < 40) begin
            if (out_valid) saw_valid = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int         lat;
        int         n;
        bit         sv;
        logic [15:0] held;

        repeat (2) @(negedge clk);
        chk("rst_ui", 16'(dut_ui), 16'h0);
        chk("rst_uio", 16'(dut_uio), 16'h0);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h0);
        chk("rst_busy", 16'(busy), 16'h1);
        chk("rst_out_result", out_result, 16'h0);
        rst = 1'b0;
        count_flush(n, sv);
        chk("flush_len", 16'(n), 16'd11);

        txn(16'h1234, 16'hABCD, 1'b0, lat);
        chk("pin_lat", 16'(lat), 16'd12);
        chk("pin_k0", {ui_log[0], uio_log[0]}, 16'h0100);
        chk("pin_k1", {ui_log[1], uio_log[1]}, 16'h34CD);
        chk("pin_k2", {ui_log[2], uio_log[2]}, 16'h12AB);
        for (int k = 3; k < 12; k++) chk("pin_idle", {ui_log[k], uio_log[k]}, 16'h0000);
        chk("peer_result", out_result, 16'hC35A);
        consume();

        txn(16'h3C00, 16'h3C00, 1'b1, lat);
        chk("e2e_lat", 16'(lat), 16'd12);
        chk("e2e_result", out_result, 16'h3C00);
        consume();

        txn(16'h0080, 16'h7F00, 1'b0, lat);
        chk("zero_byte_result", out_result, 16'h00FF);
        chk("zero_byte_k1", {ui_log[1], uio_log[1]}, 16'h8000);
        consume();

        wait_ready();
        in_valid  = 1'b1;
        in_a      = 16'h4000;
        in_b      = 16'h4200;
        out_ready = 1'b0;
        @(negedge clk);
        in_a = 16'h3C00;
        in_b = 16'h3C00;
        wait_valid(lat);
        chk("bp_first", out_result, 16'h46A3);
        held = out_result;
        repeat (20) begin
            @(negedge clk);
            chk("bp_valid", 16'(out_valid), 16'h1);
            chk("bp_result", out_result, held);
            chk("bp_in_ready", 16'(in_ready), 16'h0);
            chk("bp_no_start", 16'(dut_ui), 16'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n = 1;
        while (dut_ui != 8'h01 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_accept_gap", 16'(n), 16'd2);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_second_lat", 16'(lat), 16'd12);
        chk("bp_second", out_result, 16'h3C00);
        consume();

        wait_ready();
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'hABCD;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_result", out_result, 16'h0);
        count_flush(n, sv);
        chk("mid_rst_flush", 16'(n), 16'd11);
        chk("mid_rst_no_valid", 16'(sv), 16'h0);
        txn(16'h4000, 16'h4200, 1'b1, lat);
        chk("post_rst_lat", 16'(lat), 16'd12);
        chk("post_rst_result", out_result, 16'h46A3);
        consume();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
